// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared prefetch state enum and fetch window constants
package y86_pkg;

  localparam int LINE_BYTES = 8;
  localparam int WIN_BYTES  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL0,
    ST_FILL1,
    ST_READY,
    ST_ERROR
  } pf_state_t;

endpackage

// File: rtl/instr_align.sv
// rtl/instr_align.sv - extract the 10-byte fetch window from the 16-byte line buffer
module instr_align
  import y86_pkg::*;
(
  input  logic [127:0]             buf_data,
  input  logic [3:0]               offset,
  output logic [0:WIN_BYTES*8-1]   window
);

  // Byte k of the window is buffer byte offset+k; bytes past the buffer end read as zero.
  always_comb begin
    window = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      if (int'(offset) + k < 16) begin
        window[8*k +: 8] = buf_data[8*(int'(offset) + k) +: 8];
      end
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - two-line instruction prefetch buffer (optional INSTR_PREFETCH_SHIFT_EN line shift)
module instr_prefetch
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 256,
  parameter int LINE_BYTES = 8
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [63:0]              PC,
  input  logic                     pc_valid,
  output logic [0:WIN_BYTES*8-1]   instr,
  output logic                     instr_ready,
  output logic                     imem_error,
  output logic                     mem_req,
  output logic [63:0]              mem_addr,
  input  logic [63:0]              mem_rdata,
  input  logic                     mem_ack,
  input  logic                     mem_err
);

  pf_state_t                state_q, state_n;
  logic [63:0]              buf_base_q, buf_base_n;
  logic [63:0]              line0_q, line0_n;
  logic [63:0]              line1_q, line1_n;
  logic                     v0_q, v0_n;
  logic                     v1_q, v1_n;
  logic [63:0]              cur_pc_q, cur_pc_n;
  logic                     discard_q, discard_n;
  logic [0:WIN_BYTES*8-1]   instr_n;
  logic                     instr_ready_n, imem_error_n, mem_req_n;
  logic [63:0]              mem_addr_n;

  logic [127:0]             align_buf;
  logic [3:0]               align_off;
  logic [0:WIN_BYTES*8-1]   align_out;

  logic [63:0]              line_mask, pc_base;
  logic [64:0]              nl_sum, bl_sum;
  logic                     nl_oor, bl_oor, pc_oor, hit, stale, shift_ok;

  instr_align u_align (
    .buf_data (align_buf),
    .offset   (align_off),
    .window   (align_out)
  );

  // Address arithmetic: carry out of bit 63 marks a wrapped (hence invalid) line address.
  always_comb begin
    line_mask = ~(64'(LINE_BYTES) - 64'd1);
    pc_base   = PC & line_mask;
    nl_sum    = {1'b0, pc_base} + 65'(LINE_BYTES);
    nl_oor    = nl_sum[64] || (nl_sum[63:0] >= 64'(IMEM_BYTES));
    bl_sum    = {1'b0, buf_base_q} + 65'(LINE_BYTES);
    bl_oor    = bl_sum[64] || (bl_sum[63:0] >= 64'(IMEM_BYTES));
    pc_oor    = PC >= 64'(IMEM_BYTES);
    hit       = v0_q && v1_q && (PC >= buf_base_q) &&
                (({1'b0, PC} + 65'(WIN_BYTES - 1)) <= ({1'b0, buf_base_q} + 65'(2*LINE_BYTES - 1)));
    stale     = !pc_valid || (PC != cur_pc_q);
`ifdef INSTR_PREFETCH_SHIFT_EN
    shift_ok  = v1_q && !bl_sum[64] && (pc_base == bl_sum[63:0]);
`else
    shift_ok  = 1'b0;
`endif
  end

  // Next-state and next-register logic for the fill/ready/error sequencer.
  always_comb begin
    state_n       = state_q;
    buf_base_n    = buf_base_q;
    line0_n       = line0_q;
    line1_n       = line1_q;
    v0_n          = v0_q;
    v1_n          = v1_q;
    cur_pc_n      = cur_pc_q;
    discard_n     = discard_q;
    instr_n       = instr;
    instr_ready_n = instr_ready;
    imem_error_n  = imem_error;
    mem_req_n     = mem_req;
    mem_addr_n    = mem_addr;
    align_buf     = {line1_q, line0_q};
    align_off     = PC[3:0] - buf_base_q[3:0];

    case (state_q)
      ST_IDLE: begin
        if (pc_valid) begin
          cur_pc_n  = PC;
          discard_n = 1'b0;
          if (pc_oor) begin
            state_n       = ST_ERROR;
            instr_n       = '0;
            instr_ready_n = 1'b1;
            imem_error_n  = 1'b1;
          end else if (hit) begin
            state_n       = ST_READY;
            instr_n       = align_out;
            instr_ready_n = 1'b1;
          end else if (shift_ok) begin
            line0_n    = line1_q;
            v0_n       = 1'b1;
            buf_base_n = pc_base;
            align_off  = PC[3:0] - pc_base[3:0];
            if (nl_oor) begin
              line1_n       = '0;
              v1_n          = 1'b1;
              align_buf     = {64'd0, line1_q};
              state_n       = ST_READY;
              instr_n       = align_out;
              instr_ready_n = 1'b1;
            end else begin
              v1_n       = 1'b0;
              mem_req_n  = 1'b1;
              mem_addr_n = nl_sum[63:0];
              state_n    = ST_FILL1;
            end
          end else begin
            buf_base_n = pc_base;
            v0_n       = 1'b0;
            v1_n       = 1'b0;
            mem_req_n  = 1'b1;
            mem_addr_n = pc_base;
            state_n    = ST_FILL0;
          end
        end
      end

      ST_FILL0, ST_FILL1: begin
        if (stale) discard_n = 1'b1;
        align_off = cur_pc_q[3:0] - buf_base_q[3:0];
        if (mem_ack) begin
          if (discard_q || stale) begin
            // Fetch moved on: drop the data and re-evaluate the new PC from IDLE.
            mem_req_n = 1'b0;
            state_n   = ST_IDLE;
          end else if (mem_err) begin
            mem_req_n     = 1'b0;
            v0_n          = 1'b0;
            v1_n          = 1'b0;
            instr_n       = '0;
            instr_ready_n = 1'b1;
            imem_error_n  = 1'b1;
            state_n       = ST_ERROR;
          end else if (state_q == ST_FILL0) begin
            line0_n = mem_rdata;
            v0_n    = 1'b1;
            if (bl_oor) begin
              // Line past the end of memory reads as zeros (halt).
              line1_n       = '0;
              v1_n          = 1'b1;
              align_buf     = {64'd0, mem_rdata};
              mem_req_n     = 1'b0;
              instr_n       = align_out;
              instr_ready_n = 1'b1;
              state_n       = ST_READY;
            end else begin
              mem_addr_n = bl_sum[63:0];
              state_n    = ST_FILL1;
            end
          end else begin
            line1_n       = mem_rdata;
            v1_n          = 1'b1;
            align_buf     = {mem_rdata, line0_q};
            mem_req_n     = 1'b0;
            instr_n       = align_out;
            instr_ready_n = 1'b1;
            state_n       = ST_READY;
          end
        end
      end

      ST_READY: begin
        if (stale) begin
          instr_ready_n = 1'b0;
          state_n       = ST_IDLE;
        end
      end

      ST_ERROR: begin
        if (stale) begin
          instr_ready_n = 1'b0;
          imem_error_n  = 1'b0;
          state_n       = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and buffer registers; reset clears mem_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_base_q  <= '0;
      line0_q     <= '0;
      line1_q     <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      cur_pc_q    <= '0;
      discard_q   <= 1'b0;
      instr       <= '0;
      instr_ready <= 1'b0;
      imem_error  <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else begin
      state_q     <= state_n;
      buf_base_q  <= buf_base_n;
      line0_q     <= line0_n;
      line1_q     <= line1_n;
      v0_q        <= v0_n;
      v1_q        <= v1_n;
      cur_pc_q    <= cur_pc_n;
      discard_q   <= discard_n;
      instr       <= instr_n;
      instr_ready <= instr_ready_n;
      imem_error  <= imem_error_n;
      mem_req     <= mem_req_n;
      mem_addr    <= mem_addr_n;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - directed self-checking bench for instr_prefetch
module tb_instr_prefetch;

  logic         clk;
  logic         rst_n;
  logic [63:0]  PC;
  logic         pc_valid;
  logic [0:79]  instr;
  logic         instr_ready;
  logic         imem_error;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic [63:0]  mem_rdata;
  logic         mem_ack;
  logic         mem_err;

  int           n_total = 0;
  int           n_bad   = 0;
  logic         resp_en;
  logic         err_next;
  logic         req_seen;
  int           wait_cnt;
  logic [63:0]  req_log[$];

  instr_prefetch #(.IMEM_BYTES(256), .LINE_BYTES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PC          (PC),
    .pc_valid    (pc_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .imem_error  (imem_error),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_err     (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    logic [7:0] b;
    if (a < 64'd16) begin
      case (a[3:0])
        4'd0:  b = 8'h10;
        4'd1:  b = 8'h20;
        4'd2:  b = 8'h01;
        4'd3:  b = 8'h30;
        4'd4:  b = 8'h02;
        4'd8:  b = 8'h40;
        4'd9:  b = 8'h50;
        4'd10: b = 8'h60;
        4'd11: b = 8'h70;
        4'd12: b = 8'h80;
        4'd13: b = 8'h90;
        4'd14: b = 8'ha0;
        4'd15: b = 8'hb0;
        default: b = 8'h00;
      endcase
    end else begin
      b = a[7:0] * 8'd3 + 8'd1;
    end
    return b;
  endfunction

  function automatic logic [63:0] line_of(input logic [63:0] a);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = mem_byte(a + 64'(k));
    return d;
  endfunction

  function automatic logic [0:79] exp_win(input logic [63:0] pc);
    logic [0:79] e;
    logic [63:0] a;
    for (int k = 0; k < 10; k++) begin
      a = pc + 64'(k);
      e[8*k +: 8] = (a < 64'd256) ? mem_byte(a) : 8'h00;
    end
    return e;
  endfunction

  // One clock: advance to the falling edge, then play the memory side.
  task automatic step();
    @(negedge clk);
    if (mem_req) req_seen = 1'b1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
    end else if (resp_en && mem_req) begin
      wait_cnt++;
      if (wait_cnt == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = line_of(mem_addr);
        mem_err   = err_next;
        err_next  = 1'b0;
        req_log.push_back(mem_addr);
        wait_cnt  = 0;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!instr_ready && n < 60);
    if (!instr_ready) check_eq({tag, "_timeout"}, 128'(instr_ready), 128'd1);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!mem_req && n < 20);
    if (!mem_req) check_eq({tag, "_timeout"}, 128'(mem_req), 128'd1);
  endtask

  initial begin
    rst_n = 1'b0; PC = '0; pc_valid = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0; mem_err = 1'b0;
    resp_en = 1'b1; err_next = 1'b0; req_seen = 1'b0; wait_cnt = 0;

    step(); step();
    check_eq("rst_ready", 128'(instr_ready), 128'd0);
    check_eq("rst_err",   128'(imem_error),  128'd0);
    check_eq("rst_req",   128'(mem_req),     128'd0);
    check_eq("rst_addr",  128'(mem_addr),    128'd0);
    check_eq("rst_instr", 128'(instr),       128'd0);
    rst_n = 1'b1;

    // Cold miss at PC=0: two line reads, addr 0 then 8.
    req_log.delete();
    PC = 64'd0; pc_valid = 1'b1;
    wait_ready("cold");
    check_eq("cold_nreq", 128'(req_log.size()), 128'd2);
    check_eq("cold_a0",   128'(req_log[0]), 128'd0);
    check_eq("cold_a1",   128'(req_log[1]), 128'd8);
    check_eq("cold_b0",   128'(instr[0:7]),  128'h10);
    check_eq("cold_b1",   128'(instr[8:15]), 128'h20);
    check_eq("cold_win",  128'(instr), 128'(exp_win(64'd0)));

    // Hit at PC=3: ready drops, returns one edge later, no memory access.
    req_log.delete(); req_seen = 1'b0;
    PC = 64'd3;
    step();
    check_eq("hit_drop", 128'(instr_ready), 128'd0);
    step();
    check_eq("hit_ready", 128'(instr_ready), 128'd1);
    check_eq("hit_b0",    128'(instr[0:7]), 128'h30);
    check_eq("hit_win",   128'(instr), 128'(exp_win(64'd3)));
    check_eq("hit_noreq", 128'(req_seen), 128'd0);

    // PC=13 straddles past line1.
    req_log.delete();
    PC = 64'd13;
    wait_ready("pc13");
`ifdef INSTR_PREFETCH_SHIFT_EN
    check_eq("pc13_nreq", 128'(req_log.size()), 128'd1);
    check_eq("pc13_a0",   128'(req_log[0]), 128'd16);
`else
    check_eq("pc13_nreq", 128'(req_log.size()), 128'd2);
    check_eq("pc13_a0",   128'(req_log[0]), 128'd8);
    check_eq("pc13_a1",   128'(req_log[1]), 128'd16);
`endif
    check_eq("pc13_win", 128'(instr), 128'(exp_win(64'd13)));

    // PC=250: line1 would be at 256, so it is zero-filled without a read.
    req_log.delete();
    PC = 64'd250;
    wait_ready("pc250");
    check_eq("pc250_nreq", 128'(req_log.size()), 128'd1);
    check_eq("pc250_a0",   128'(req_log[0]), 128'd248);
    check_eq("pc250_tail", 128'(instr[48:79]), 128'd0);
    check_eq("pc250_win",  128'(instr), 128'(exp_win(64'd250)));

    // PC=256 is out of range: error, no request.
    req_seen = 1'b0;
    PC = 64'd256;
    for (int i = 0; i < 4; i++) step();
    check_eq("oor_err",   128'(imem_error),  128'd1);
    check_eq("oor_ready", 128'(instr_ready), 128'd1);
    check_eq("oor_instr", 128'(instr),       128'd0);
    check_eq("oor_noreq", 128'(req_seen),    128'd0);

    // Memory error on the first ack, then recovery on a PC change.
    err_next = 1'b1;
    PC = 64'd16;
    begin
      int n;
      n = 0;
      do begin step(); n++; end while (!imem_error && n < 30);
    end
    check_eq("merr_err", 128'(imem_error), 128'd1);
    req_log.delete();
    PC = 64'd0;
    step();
    check_eq("merr_clear", 128'(imem_error), 128'd0);
    wait_ready("merr_refill");
    check_eq("merr_nreq", 128'(req_log.size()), 128'd2);
    check_eq("merr_win",  128'(instr), 128'(exp_win(64'd0)));

    // PC change while FILL0 is outstanding: its data is discarded.
    req_log.delete();
    PC = 64'd32;
    wait_req("chg");
    PC = 64'd40;
    wait_ready("chg");
    check_eq("chg_nreq", 128'(req_log.size()), 128'd3);
    check_eq("chg_a0",   128'(req_log[0]), 128'd32);
    check_eq("chg_a2",   128'(req_log[2]), 128'd48);
    check_eq("chg_win",  128'(instr), 128'(exp_win(64'd40)));

    // Dropping pc_valid leaves READY at the next edge.
    pc_valid = 1'b0;
    step();
    check_eq("drop_ready", 128'(instr_ready), 128'd0);

    // Reset in the middle of a fill.
    pc_valid = 1'b1;
    PC = 64'd64;
    wait_req("rst_fill");
    resp_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req",  128'(mem_req),  128'd0);
    check_eq("arst_addr", 128'(mem_addr), 128'd0);
    pc_valid = 1'b0;
    step();
    rst_n = 1'b1;
    wait_cnt = 0;
    mem_rdata = 64'hdead_beef_0bad_f00d;
    mem_ack = 1'b1;
    step();
    step();
    check_eq("late_req",   128'(mem_req),     128'd0);
    check_eq("late_ready", 128'(instr_ready), 128'd0);
    check_eq("late_err",   128'(imem_error),  128'd0);
    check_eq("late_instr", 128'(instr),       128'd0);

    resp_en = 1'b1;
    req_log.delete();
    pc_valid = 1'b1;
    PC = 64'd0;
    wait_ready("post_rst");
    check_eq("post_rst_nreq", 128'(req_log.size()), 128'd2);
    check_eq("post_rst_win",  128'(instr), 128'(exp_win(64'd0)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter IMEM_BYTES, 256, size of instruction memory in bytes; addresses >= IMEM_BYTES are invalid.
REQ-002 Parameter LINE_BYTES, 8, bytes returned per memory transaction; fixed at 8.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 PC  input  64  byte address of the instruction that fetch wants.
REQ-006 pc_valid  input  1  fetch is requesting the window at PC.
REQ-007 instr  output  80 [0:79]  10-byte window; byte at PC sits in instr[0:7], byte PC+9 in instr[72:79].
REQ-008 instr_ready  output  1  instr is valid for the current PC.
REQ-009 imem_error  output  1  PC is out of range, or a memory error occurred.
REQ-010 mem_req  output  1  line read request.
REQ-011 mem_addr  output  64  8-byte-aligned line address; held stable while mem_req=1.
REQ-012 mem_rdata  input  64  line data; byte at mem_addr+k is in bits [8k+7:8k].
REQ-013 mem_ack  input  1  mem_rdata valid this cycle; ends the transaction.
REQ-014 mem_err  input  1  qualified by mem_ack; the read failed.

Function
REQ-015 Two-line buffer: buf_base (aligned to 8), line0 = buf_base..+7, line1 = buf_base+8..+15, one valid bit per line.
REQ-016 States: IDLE, FILL0, FILL1, READY, ERROR.
REQ-017 Hit: PC >= buf_base, PC+9 <= buf_base+15, both lines valid. IDLE+pc_valid+hit -> READY next edge (1-cycle latency), no memory access.
REQ-018 Miss: buf_base := PC & ~7 and both lines are invalidated; FILL0 (line0), then FILL1 (line1) -> READY one edge after the last mem_ack.
REQ-019 mem_req stays high with mem_addr constant until mem_ack is sampled; mem_ack is ignored when mem_req=0; only one transaction is outstanding.
REQ-020 instr = buffer bytes at offset (PC - buf_base) .. +9; it is registered, and it is stable for as long as instr_ready=1.
REQ-021 READY holds while pc_valid=1 and PC is unchanged. A PC change or a pc_valid drop -> IDLE next edge, and instr_ready drops at that same edge.
REQ-022 PC change during FILL0/FILL1: the outstanding transaction completes, its data is discarded, and the block re-evaluates hit/miss on the new PC.
REQ-023 PC >= IMEM_BYTES with pc_valid=1 -> ERROR next edge, no mem_req, imem_error=1, instr_ready=1, instr=0.
REQ-024 Line1 address >= IMEM_BYTES: FILL1 is skipped and line1 is zero-filled (it decodes as halt).
REQ-025 mem_ack with mem_err=1 -> ERROR; both lines are invalidated.
REQ-026 ERROR exits to IDLE only on a PC change or a pc_valid drop.
REQ-027 Address arithmetic is 64-bit unsigned and wraps mod 2^64; any wrapped line address counts as out of range.

Reset
REQ-028 While rst_n=0: state=IDLE, line valids=0, buf_base=0, instr=0, instr_ready=0, imem_error=0, mem_req=0, mem_addr=0.
REQ-029 Reset mid-FILL drops mem_req immediately (asynchronously); a late mem_ack after reset is ignored.

Configuration
REQ-030 Macro INSTR_PREFETCH_SHIFT_EN.
- Defined: on a miss where PC & ~7 == buf_base+8 and line1 is valid, line1 moves to line0, buf_base += 8, and only line1 is fetched (one transaction).
- Undefined: every miss performs the full two-line refill of REQ-018.

Structure
REQ-031 Shared package y86_pkg holds the prefetch state enum and the constants LINE_BYTES=8 and WIN_BYTES=10; fetch uses WIN_BYTES for its instr width.
REQ-032 One sub-module, instr_align: combinational extraction of the 10-byte window from the 16-byte buffer by a 4-bit offset.

Verification
REQ-033 Memory bytes 0..15 = 10 20 01 30 02 00 ...; PC=0, pc_valid=1, mem_ack 2 cycles after each req -> two reqs (addr 0, then 8), then instr_ready with instr[0:7]=0x10, instr[8:15]=0x20.
REQ-034 After REQ-033, PC=3 -> hit, instr_ready one edge later, instr[0:7]=0x30, mem_req stays 0.
REQ-035 PC=13 after PC=3:
- INSTR_PREFETCH_SHIFT_EN defined: one req at addr 16, buf_base=8.
- Undefined: reqs at addr 8 then 16.
REQ-036 PC=250 with IMEM_BYTES=256 -> a single req at addr 248, no line1 req; instr bytes 6..9 = 0. PC=256 -> imem_error=1 with no req.
REQ-037 Return mem_err=1 on the first ack -> ERROR, imem_error=1; then change PC to 0 -> IDLE, imem_error=0, refill proceeds.
REQ-038 Assert rst_n=0 while mem_req=1 -> mem_req=0 in the same cycle; a mem_ack pulse after reset causes no state change.
